// File: rtl/dmem_controller.sv
`default_nettype none
// ============================================================================
// Module   : dmem_controller
// Brief    : Round-robin arbiter relaying LSU read/write requests to one memory port
// Revision : 1.0
// ============================================================================
module dmem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_request,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_request,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAYING      = 2'd3
  } state_t;

  state_t                             r_state, w_state_next;
  logic [IDX_W-1:0]                   r_ptr, w_ptr_next;
  logic [IDX_W-1:0]                   r_grant, w_grant_next;
  logic                               r_grant_is_read, w_grant_is_read_next;
  logic [NUM_CONSUMERS-1:0]           r_read_ready, w_read_ready_next;
  logic [NUM_CONSUMERS-1:0]           r_write_ready, w_write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data, w_read_data_next;
  logic                               r_mem_read_valid, w_mem_read_valid_next;
  logic [ADDR_BITS-1:0]               r_mem_read_address, w_mem_read_address_next;
  logic                               r_mem_write_valid, w_mem_write_valid_next;
  logic [ADDR_BITS-1:0]               r_mem_write_address, w_mem_write_address_next;
  logic [DATA_BITS-1:0]               r_mem_write_data, w_mem_write_data_next;
  logic                               w_found;
  logic [IDX_W-1:0]                   w_sel;

  // Scan from the pointer downwards so the closest pending consumer wins last.
  always_comb begin : p_search
    int               idx;
    logic [IDX_W-1:0] cand;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    cand    = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
      cand = idx[IDX_W-1:0];
      if (consumer_read_request[cand] || consumer_write_request[cand]) begin
        w_found = 1'b1;
        w_sel   = cand;
      end
    end
  end

  always_comb begin : p_next
    w_state_next             = r_state;
    w_ptr_next               = r_ptr;
    w_grant_next             = r_grant;
    w_grant_is_read_next     = r_grant_is_read;
    w_read_ready_next        = r_read_ready;
    w_write_ready_next       = r_write_ready;
    w_read_data_next         = r_read_data;
    w_mem_read_valid_next    = r_mem_read_valid;
    w_mem_read_address_next  = r_mem_read_address;
    w_mem_write_valid_next   = r_mem_write_valid;
    w_mem_write_address_next = r_mem_write_address;
    w_mem_write_data_next    = r_mem_write_data;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_next = w_sel;
          w_ptr_next   = (w_sel == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : w_sel + 1'b1;
          if (consumer_read_request[w_sel]) begin
            w_grant_is_read_next    = 1'b1;
            w_mem_read_valid_next   = 1'b1;
            w_mem_read_address_next = consumer_read_address[w_sel*ADDR_BITS +: ADDR_BITS];
            w_state_next            = READ_WAITING;
          end else begin
            w_grant_is_read_next     = 1'b0;
            w_mem_write_valid_next   = 1'b1;
            w_mem_write_address_next = consumer_write_address[w_sel*ADDR_BITS +: ADDR_BITS];
            w_mem_write_data_next    = consumer_write_data[w_sel*DATA_BITS +: DATA_BITS];
            w_state_next             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          w_mem_read_valid_next                           = 1'b0;
          w_read_data_next[r_grant*DATA_BITS +: DATA_BITS] = mem_read_data;
          w_read_ready_next[r_grant]                      = 1'b1;
          w_state_next                                    = RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          w_mem_write_valid_next      = 1'b0;
          w_write_ready_next[r_grant] = 1'b1;
          w_state_next                = RELAYING;
        end
      end
      RELAYING: begin
        if (r_grant_is_read ? !consumer_read_request[r_grant]
                            : !consumer_write_request[r_grant]) begin
          w_read_ready_next  = '0;
          w_write_ready_next = '0;
          w_state_next       = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= IDLE;
      r_ptr               <= '0;
      r_grant             <= '0;
      r_grant_is_read     <= 1'b0;
      r_read_ready        <= '0;
      r_write_ready       <= '0;
      r_read_data         <= '0;
      r_mem_read_valid    <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_valid   <= 1'b0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
    end else begin
      r_state             <= w_state_next;
      r_ptr               <= w_ptr_next;
      r_grant             <= w_grant_next;
      r_grant_is_read     <= w_grant_is_read_next;
      r_read_ready        <= w_read_ready_next;
      r_write_ready       <= w_write_ready_next;
      r_read_data         <= w_read_data_next;
      r_mem_read_valid    <= w_mem_read_valid_next;
      r_mem_read_address  <= w_mem_read_address_next;
      r_mem_write_valid   <= w_mem_write_valid_next;
      r_mem_write_address <= w_mem_write_address_next;
      r_mem_write_data    <= w_mem_write_data_next;
    end
  end

  assign consumer_read_ready  = r_read_ready;
  assign consumer_read_data   = r_read_data;
  assign consumer_write_ready = r_write_ready;
  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_controller
// Brief    : Directed and randomized checks of dmem_controller against a transaction model
// Revision : 1.0
// ============================================================================
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  consumer_read_ready, consumer_write_ready;
  logic [31:0] consumer_read_data;
  logic        mem_read_valid, mem_write_valid;
  logic [7:0]  mem_read_address, mem_write_address, mem_write_data;
  logic        mem_read_ready, mem_write_ready;
  logic [7:0]  mem_read_data;

  int total = 0;
  int bad   = 0;

  // Memory environment (written by the DUT) and the independent model image.
  logic [7:0] mem_array [256];
  logic [7:0] model_mem [256];
  int         mem_wait = 0;
  int         wcnt     = 0;

  dmem_controller #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_request  (rd_req),
    .consumer_read_address  (rd_addr),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_request (wr_req),
    .consumer_write_address (wr_addr),
    .consumer_write_data    (wr_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One clock: sample after the edge, check exclusivity, then act as the memory.
  task automatic tick();
    @(posedge clk);
    #1;
    total++;
    if ((mem_read_valid && mem_write_valid) ||
        $countones({consumer_read_ready, consumer_write_ready}) > 1) begin
      bad++;
      $display("FAIL exclusive: mem_rv=%0b mem_wv=%0b rd_rdy=%b wr_rdy=%b, required at most one",
               mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready);
    end
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    if (mem_read_valid || mem_write_valid) begin
      if (wcnt >= mem_wait) begin
        if (mem_read_valid) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_array[mem_read_address];
        end else begin
          mem_write_ready              = 1'b1;
          mem_array[mem_write_address] = mem_write_data;
        end
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    rd_req  = '0;
    wr_req  = '0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    mem_wait = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] d);
    mem_array[a] = d;
    model_mem[a] = d;
  endtask

  task automatic wait_ready(input int bound, output int who, output logic isrd);
    who  = -1;
    isrd = 1'b0;
    for (int t = 0; t < bound && who < 0; t++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (consumer_read_ready[c]) begin
          who = c; isrd = 1'b1;
        end else if (consumer_write_ready[c]) begin
          who = c; isrd = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
         consumer_read_ready, consumer_write_ready, consumer_read_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rv=%0b wv=%0b ra=%h wa=%h wd=%h rrdy=%b wrdy=%b rdata=%h, required all 0",
               mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
               consumer_read_ready, consumer_write_ready, consumer_read_data);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_mem(8'h10, 8'hA5);
    rd_req[1] = 1'b1;
    rd_addr[15:8] = 8'h10;
    tick();
    total++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10 || consumer_read_ready !== 4'b0) begin
      bad++;
      $display("FAIL single_read_cycle1: rv=%0b addr=%h rrdy=%b, required 1/10/0000",
               mem_read_valid, mem_read_address, consumer_read_ready);
    end
    tick();
    total++;
    if (consumer_read_ready !== 4'b0010 || consumer_read_data[15:8] !== 8'hA5 || mem_read_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_read_cycle2: rrdy=%b data=%h rv=%0b, required 0010/a5/0",
               consumer_read_ready, consumer_read_data[15:8], mem_read_valid);
    end
    tick();
    total++;
    if (consumer_read_ready !== 4'b0010) begin
      bad++;
      $display("FAIL single_read_hold: rrdy=%b, required 0010", consumer_read_ready);
    end
    rd_req[1] = 1'b0;
    tick();
    total++;
    if (consumer_read_ready !== 4'b0 || consumer_read_data[15:8] !== 8'hA5) begin
      bad++;
      $display("FAIL single_read_release: rrdy=%b data=%h, required 0000/a5",
               consumer_read_ready, consumer_read_data[15:8]);
    end
  endtask

  task automatic test_write_wait();
    do_reset();
    mem_wait = 3;
    wr_req[2] = 1'b1;
    wr_addr[23:16] = 8'h20;
    wr_data[23:16] = 8'h3C;
    for (int t = 1; t <= 4; t++) begin
      tick();
      total++;
      if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h20 || mem_write_data !== 8'h3C ||
          consumer_write_ready !== 4'b0) begin
        bad++;
        $display("FAIL write_wait_cycle%0d: wv=%0b addr=%h data=%h wrdy=%b, required 1/20/3c/0000",
                 t, mem_write_valid, mem_write_address, mem_write_data, consumer_write_ready);
      end
      if (t == 1) begin
        wr_addr[23:16] = 8'h99;
        wr_data[23:16] = 8'hFF;
      end
    end
    tick();
    model_mem[8'h20] = 8'h3C;
    total++;
    if (consumer_write_ready !== 4'b0100 || mem_write_valid !== 1'b0 || mem_array[8'h20] !== 8'h3C) begin
      bad++;
      $display("FAIL write_wait_done: wrdy=%b wv=%0b mem=%h, required 0100/0/3c",
               consumer_write_ready, mem_write_valid, mem_array[8'h20]);
    end
    wr_req[2] = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int   order [5] = '{0, 1, 2, 3, 0};
    int   who;
    logic isrd;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_mem(8'(8'h40 + c), 8'(8'hC0 + 3 * c));
      rd_req[c] = 1'b1;
      rd_addr[c*8 +: 8] = 8'(8'h40 + c);
    end
    for (int k = 0; k < 5; k++) begin
      wait_ready(20, who, isrd);
      total++;
      if (who !== order[k] || isrd !== 1'b1 ||
          consumer_read_data[order[k]*8 +: 8] !== model_mem[8'(8'h40 + order[k])]) begin
        bad++;
        $display("FAIL round_robin_%0d: consumer=%0d read=%0b data=%h, required consumer=%0d read=1 data=%h",
                 k, who, isrd, consumer_read_data[order[k]*8 +: 8], order[k], model_mem[8'(8'h40 + order[k])]);
      end
      if (who >= 0) begin
        rd_req[who] = 1'b0;
        tick();
        if (k == 0) rd_req[0] = 1'b1;
      end
    end
  endtask

  task automatic test_read_write_same();
    int   who;
    logic isrd;
    do_reset();
    set_mem(8'h50, 8'h5A);
    rd_req[3] = 1'b1; rd_addr[31:24] = 8'h50;
    wr_req[3] = 1'b1; wr_addr[31:24] = 8'h51; wr_data[31:24] = 8'h77;
    wait_ready(20, who, isrd);
    total++;
    if (who !== 3 || isrd !== 1'b1 || consumer_read_data[31:24] !== 8'h5A) begin
      bad++;
      $display("FAIL rw_read_first: consumer=%0d read=%0b data=%h, required 3/1/5a",
               who, isrd, consumer_read_data[31:24]);
    end
    rd_req[3] = 1'b0;
    wait_ready(20, who, isrd);
    model_mem[8'h51] = 8'h77;
    total++;
    if (who !== 3 || isrd !== 1'b0 || mem_array[8'h51] !== 8'h77) begin
      bad++;
      $display("FAIL rw_write_second: consumer=%0d read=%0b mem=%h, required 3/0/77",
               who, isrd, mem_array[8'h51]);
    end
    wr_req[3] = 1'b0;
    tick();
  endtask

  task automatic test_early_drop();
    int   who;
    logic isrd;
    do_reset();
    set_mem(8'h33, 8'h96);
    mem_wait = 2;
    rd_req[0] = 1'b1; rd_addr[7:0] = 8'h33;
    tick();
    rd_req[0] = 1'b0;
    wait_ready(10, who, isrd);
    total++;
    if (who !== 0 || isrd !== 1'b1 || consumer_read_data[7:0] !== 8'h96) begin
      bad++;
      $display("FAIL early_drop_complete: consumer=%0d read=%0b data=%h, required 0/1/96",
               who, isrd, consumer_read_data[7:0]);
    end
    tick();
    total++;
    if (consumer_read_ready !== 4'b0 || mem_read_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_drop_pulse: rrdy=%b rv=%0b, required 0000/0", consumer_read_ready, mem_read_valid);
    end
  endtask

  task automatic test_reset_mid();
    int   who;
    logic isrd;
    do_reset();
    mem_wait = 10;
    wr_req[1] = 1'b1; wr_addr[15:8] = 8'h60; wr_data[15:8] = 8'h11;
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
         consumer_read_ready, consumer_write_ready, consumer_read_data} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: wv=%0b wa=%h wd=%h wrdy=%b, required all 0",
               mem_write_valid, mem_write_address, mem_write_data, consumer_write_ready);
    end
    reset = 1'b0;
    wr_req[1] = 1'b0;
    mem_wait = 0;
    set_mem(8'h44, 8'h3E);
    rd_req[0] = 1'b1; rd_addr[7:0] = 8'h44;
    wait_ready(10, who, isrd);
    total++;
    if (who !== 0 || isrd !== 1'b1 || consumer_read_data[7:0] !== 8'h3E) begin
      bad++;
      $display("FAIL reset_mid_fresh: consumer=%0d read=%0b data=%h, required 0/1/3e",
               who, isrd, consumer_read_data[7:0]);
    end
    rd_req[0] = 1'b0;
    tick();
  endtask

  // Transaction-level model: pending set, round-robin pointer and a memory image.
  task automatic test_random();
    logic [3:0] pend_rd = '0;
    logic [3:0] pend_wr = '0;
    logic [7:0] ra [4];
    logic [7:0] wa [4];
    logic [7:0] wd [4];
    int         ptr = 0;
    int         exp_c;
    logic       exp_rd;
    int         who;
    logic       isrd;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend_rd[c] && !pend_wr[c] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) begin
            pend_rd[c] = 1'b1;
            ra[c] = 8'($urandom_range(0, 15));
            rd_req[c] = 1'b1;
            rd_addr[c*8 +: 8] = ra[c];
          end else begin
            pend_wr[c] = 1'b1;
            wa[c] = 8'($urandom_range(0, 15));
            wd[c] = 8'($urandom);
            wr_req[c] = 1'b1;
            wr_addr[c*8 +: 8] = wa[c];
            wr_data[c*8 +: 8] = wd[c];
          end
        end
      end
      if ((pend_rd | pend_wr) == 4'b0) continue;
      mem_wait = $urandom_range(0, 2);
      exp_c = -1;
      for (int k = 3; k >= 0; k--) begin
        if (pend_rd[(ptr + k) % 4] || pend_wr[(ptr + k) % 4]) exp_c = (ptr + k) % 4;
      end
      exp_rd = pend_rd[exp_c];
      wait_ready(20, who, isrd);
      total++;
      if (who !== exp_c || isrd !== exp_rd) begin
        bad++;
        $display("FAIL random_grant_%0d: consumer=%0d read=%0b, required consumer=%0d read=%0b",
                 it, who, isrd, exp_c, exp_rd);
      end
      total++;
      if (exp_rd) begin
        if (consumer_read_data[exp_c*8 +: 8] !== model_mem[ra[exp_c]]) begin
          bad++;
          $display("FAIL random_rdata_%0d: data=%h, required %h",
                   it, consumer_read_data[exp_c*8 +: 8], model_mem[ra[exp_c]]);
        end
        pend_rd[exp_c] = 1'b0;
        rd_req[exp_c]  = 1'b0;
      end else begin
        model_mem[wa[exp_c]] = wd[exp_c];
        if (mem_array[wa[exp_c]] !== wd[exp_c]) begin
          bad++;
          $display("FAIL random_wdata_%0d: mem[%h]=%h, required %h",
                   it, wa[exp_c], mem_array[wa[exp_c]], wd[exp_c]);
        end
        pend_wr[exp_c] = 1'b0;
        wr_req[exp_c]  = 1'b0;
      end
      ptr = (exp_c + 1) % 4;
      tick();
      total++;
      if ((consumer_read_ready | consumer_write_ready) !== 4'b0) begin
        bad++;
        $display("FAIL random_release_%0d: rrdy=%b wrdy=%b, required 0000",
                 it, consumer_read_ready, consumer_write_ready);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    rd_req          = '0;
    wr_req          = '0;
    rd_addr         = '0;
    wr_addr         = '0;
    wr_data         = '0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    for (int a = 0; a < 256; a++) begin
      mem_array[a] = 8'($urandom);
      model_mem[a] = mem_array[a];
    end
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_read_write_same();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_controller.md
DMEM_CONTROLLER -- requirements
Module: dmem_controller

Interface
REQ-001 The block SHALL have parameter NUM_CONSUMERS, default 4, meaning the number of LSU request ports served.
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, meaning the memory address width.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning the memory data width.
REQ-004 The block SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have consumer_read_request  input  NUM_CONSUMERS  per-LSU read request level.
REQ-007 The block SHALL have consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  per-LSU read address, packed with consumer i at bits [i*ADDR_BITS +: ADDR_BITS].
REQ-008 The block SHALL have consumer_read_ready  output  NUM_CONSUMERS  per-LSU read response valid.
REQ-009 The block SHALL have consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  per-LSU read data, packed the same way.
REQ-010 The block SHALL have consumer_write_request  input  NUM_CONSUMERS  per-LSU write request level.
REQ-011 The block SHALL have consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  per-LSU write address.
REQ-012 The block SHALL have consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  per-LSU write data.
REQ-013 The block SHALL have consumer_write_ready  output  NUM_CONSUMERS  per-LSU write acknowledge.
REQ-014 The block SHALL have mem_read_valid  output  1, mem_read_address  output  ADDR_BITS, mem_read_ready  input  1, mem_read_data  input  DATA_BITS, forming the memory read port.
REQ-015 The block SHALL have mem_write_valid  output  1, mem_write_address  output  ADDR_BITS, mem_write_data  output  DATA_BITS, mem_write_ready  input  1, forming the memory write port.

Function
REQ-016 The block SHALL be the responder for LSU requests, serving one transaction at a time over the single memory port.
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, READ_WAITING, WRITE_WAITING and RELAYING.
REQ-019 In IDLE, the block SHALL select one consumer with a pending read or write request by round-robin, starting the search at the consumer after the last one granted.
REQ-020 Consumers with no pending request SHALL be skipped at zero cost.
REQ-021 If the selected consumer has both read and write requests pending, the read SHALL be served first.
REQ-022 On a read grant, the block SHALL set mem_read_valid=1, latch the consumer's address into mem_read_address and enter READ_WAITING.
REQ-023 On a write grant, the block SHALL set mem_write_valid=1, latch the consumer's address and data into mem_write_address/mem_write_data and enter WRITE_WAITING.
REQ-024 Consumer address and data changes after the grant SHALL be ignored.
REQ-025 In READ_WAITING with mem_read_ready=1, the block SHALL clear mem_read_valid, load consumer_read_data[i] from mem_read_data, set consumer_read_ready[i]=1 and enter RELAYING.
REQ-026 In WRITE_WAITING with mem_write_ready=1, the block SHALL clear mem_write_valid, set consumer_write_ready[i]=1 and enter RELAYING.
REQ-027 In RELAYING, the block SHALL hold ready high until the granted consumer's matching request is sampled low, then clear ready and return to IDLE in that same edge.
REQ-028 The latency from a request sampled in IDLE to consumer ready high SHALL be 2 cycles with zero-wait memory, plus 1 cycle per memory wait cycle.
REQ-029 A consumer that drops its request before ready SHALL still have its memory transaction completed.
REQ-030 In that case, ready SHALL be high for exactly 1 cycle (RELAYING sees the request low immediately), with no retry.
REQ-031 At most one of consumer_read_ready/consumer_write_ready bits SHALL be high at any time.
REQ-032 mem_read_valid and mem_write_valid SHALL never be high together.
REQ-033 consumer_read_data[i] SHALL hold its value until the next read completion for consumer i.
REQ-034 The round-robin pointer SHALL wrap from NUM_CONSUMERS-1 to 0.
REQ-035 The block SHALL not issue a new grant in the same cycle it leaves RELAYING.

Reset
REQ-036 On reset=1 at a clock edge, the state SHALL be IDLE, the round-robin pointer SHALL be set so consumer 0 is searched first, and all outputs SHALL be 0, including read data.
REQ-037 Reset mid-transaction SHALL abandon the transaction; the bench SHALL deassert mem_*_ready after reset.
REQ-038 Reset SHALL take priority over all other inputs.

Verification
REQ-039 Single read: consumer 1 reads address 0x10 with memory returning 0xA5 with zero wait -> mem_read_valid=1, address 0x10 at cycle 1; consumer_read_ready[1]=1, data 0xA5 at cycle 2; ready clears the edge after request drops.
REQ-040 Write with 3 memory wait cycles: consumer 2 writes 0x3C to 0x20 -> mem_write_valid is held 4 cycles with stable address/data; consumer_write_ready[2] rises at cycle 5.
REQ-041 Round-robin: all 4 consumers request reads simultaneously after reset -> grant order is 0,1,2,3; a repeated request from 0 is not served before 1,2,3.
REQ-042 Read+write from the same consumer 3 -> the read is performed first, then the write after the RELAYING handshake.
REQ-043 Early drop: consumer 0 drops its read request while in READ_WAITING -> the memory read completes and consumer_read_ready[0] pulses exactly 1 cycle.
REQ-044 Reset asserted in WRITE_WAITING -> the next cycle all outputs are 0 and the state is IDLE; a fresh request from consumer 0 is served normally.
